lead_count_pipe: RTL and testbench

//  Parametrised, pipelined bit-count unit: count leading/trailing zeros/ones of a WIDTH-bit operand.

---
 rtl/lead_count_pipe.sv | 110 +++++++++++
 tb/tb_lead_count_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lead_count_pipe.sv
// Pipelined count-leading/trailing zeros/ones unit with valid/ready backpressure,
// synchronous flush and a sideband tag that travels with each operand.
module lead_count_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5,
  localparam int unsigned CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_all,
  output logic [TAG_W-1:0] out_tag
);

  // mode[0] inverts (count ones), mode[1] bit-reverses (count from the LSB end)
  function automatic logic [WIDTH-1:0] f_cond(input logic [WIDTH-1:0] d, input logic [1:0] m);
    logic [WIDTH-1:0] x;
    x      = m[0] ? ~d : d;
    f_cond = x;
    if (m[1]) begin
      for (int i = 0; i < WIDTH; i++) f_cond[i] = x[WIDTH-1-i];
    end
  endfunction

  // Highest set bit wins; an all-zero word yields WIDTH.
  function automatic logic [CW-1:0] f_clz(input logic [WIDTH-1:0] d);
    f_clz = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (d[i]) f_clz = CW'(WIDTH - 1 - i);
    end
  endfunction

  logic             w_advance;
  logic [WIDTH-1:0] w_cond;
  logic [CW-1:0]    w_out_cnt;
  logic             r_vld [STAGES];
  logic [TAG_W-1:0] r_tag [STAGES];

  assign w_advance = !r_vld[STAGES-1] || out_ready;
  assign w_cond    = f_cond(in_data, in_mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_vld[i] <= 1'b0;
        r_tag[i] <= '0;
      end
    end else begin
      if (flush) begin
        for (int i = 0; i < STAGES; i++) r_vld[i] <= 1'b0;
      end else if (w_advance) begin
        r_vld[0] <= in_valid;
        for (int i = 1; i < STAGES; i++) r_vld[i] <= r_vld[i-1];
      end
      if (w_advance) begin
        r_tag[0] <= in_tag;
        for (int i = 1; i < STAGES; i++) r_tag[i] <= r_tag[i-1];
      end
    end
  end

  generate
    if (STAGES == 1) begin : g_one
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (w_advance) begin
          r_cnt <= f_clz(w_cond);
        end
      end

      assign w_out_cnt = r_cnt;
    end else begin : g_multi
      // Stage 1 holds the conditioned word; the count is formed on the way into stage 2.
      logic [WIDTH-1:0] r_word;
      logic [CW-1:0]    r_cnt [STAGES-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_word <= '0;
          for (int i = 0; i < STAGES - 1; i++) r_cnt[i] <= '0;
        end else if (w_advance) begin
          r_word   <= w_cond;
          r_cnt[0] <= f_clz(r_word);
          for (int i = 1; i < STAGES - 1; i++) r_cnt[i] <= r_cnt[i-1];
        end
      end

      assign w_out_cnt = r_cnt[STAGES-2];
    end
  endgenerate

  assign in_ready  = w_advance;
  assign out_valid = r_vld[STAGES-1];
  assign out_count = w_out_cnt;
  assign out_all   = (w_out_cnt == CW'(WIDTH));
  assign out_tag   = r_tag[STAGES-1];

endmodule

// File: tb/tb_lead_count_pipe.sv
// Scoreboard bench for lead_count_pipe: directed cases, stall/flush/reset, random
// streaming on a 32-bit 2-stage unit, plus spot checks on 8/1 and 64/4 variants.
module tb_lead_count_pipe;
  localparam int W = 32, TW = 5, CW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, in_ready, flush, out_valid, out_ready, out_all;
  logic [W-1:0]  in_data;
  logic [1:0]    in_mode;
  logic [TW-1:0] in_tag, out_tag;
  logic [CW-1:0] out_count;

  lead_count_pipe #(.WIDTH(W), .STAGES(2), .TAG_W(TW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count), .out_all(out_all), .out_tag(out_tag)
  );

  logic       v8, rdy8, ov8, all8;
  logic [7:0] d8;
  logic [1:0] m8;
  logic [2:0] t8, ot8;
  logic [3:0] c8;
  lead_count_pipe #(.WIDTH(8), .STAGES(1), .TAG_W(3)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_data(d8), .in_mode(m8),
    .in_tag(t8), .flush(1'b0), .out_valid(ov8), .out_ready(1'b1), .out_count(c8),
    .out_all(all8), .out_tag(ot8)
  );

  logic        v64, rdy64, ov64, all64;
  logic [63:0] d64;
  logic [1:0]  m64;
  logic [4:0]  t64, ot64;
  logic [6:0]  c64;
  lead_count_pipe #(.WIDTH(64), .STAGES(4), .TAG_W(5)) u_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(rdy64), .in_data(d64), .in_mode(m64),
    .in_tag(t64), .flush(1'b0), .out_valid(ov64), .out_ready(1'b1), .out_count(c64),
    .out_all(all64), .out_tag(ot64)
  );

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          all;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   pops  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Walk from the chosen end, counting bits equal to the fill value until one differs.
  function automatic exp_t model(input logic [W-1:0] d, input logic [1:0] m,
                                 input logic [TW-1:0] t);
    int n;
    bit stop;
    n    = 0;
    stop = 1'b0;
    for (int k = 0; k < W; k++) begin
      int idx;
      idx = m[1] ? k : W - 1 - k;
      if (!stop && d[idx] == m[0]) n++;
      else stop = 1'b1;
    end
    model.cnt = CW'(n);
    model.all = (n == W);
    model.tag = t;
  endfunction

  // Monitor: pops on every output transfer; also checks outputs hold while stalled.
  logic        pstall = 1'b0, pflush = 1'b0;
  logic [63:0] pdat;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pstall = 1'b0;
    end else begin
      if (pstall && !pflush) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", {out_count, out_all, out_tag}, pdat);
      end
      if (out_valid) check("spurious_out", q.size() > 0, 1);
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        pops++;
        check("count", out_count, e.cnt);
        check("all", out_all, e.all);
        check("tag", out_tag, e.tag);
      end
      pstall = out_valid && !out_ready;
      pdat   = {40'd0, out_count, out_all, out_tag};
      pflush = flush;
    end
  end

  task automatic cyc(output bit acc);
    bit fl;
    @(negedge clk);
    acc = rst_n && in_valid && in_ready;
    fl  = flush;
    if (acc && !fl) q.push_back(model(in_data, in_mode, in_tag));
    @(posedge clk);
    #1;
    if (fl) q.delete();
  endtask

  task automatic idle(input int n);
    bit a;
    in_valid = 1'b0;
    repeat (n) cyc(a);
  endtask

  task automatic send(input logic [W-1:0] d, input logic [1:0] m, input logic [TW-1:0] t,
                      output int tries);
    bit a;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_tag   = t;
    tries    = 0;
    a        = 1'b0;
    while (!a && tries < 50) begin
      cyc(a);
      tries++;
    end
    in_valid = 1'b0;
    if (!a) check("send_timeout", 0, 1);
  endtask

  initial begin
    int       tr, p0;
    bit       a;
    logic [W-1:0] d;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b1;
    v8 = 1'b0; d8 = '0; m8 = '0; t8 = '0; v64 = 1'b0; d64 = '0; m64 = '0; t64 = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_count", out_count, 0);
    check("rst_all", out_all, 0);
    check("rst_tag", out_tag, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 8-bit, 1 stage: result visible right after the accept edge
    v8 = 1'b1; d8 = 8'h01; m8 = 2'b00; t8 = 3'd5;
    @(posedge clk); #1; v8 = 1'b0;
    check("w8_valid", ov8, 1);
    check("w8_count", c8, 7);
    check("w8_all", all8, 0);
    check("w8_tag", ot8, 5);
    v8 = 1'b1; d8 = 8'hFF; m8 = 2'b01; t8 = 3'd2;
    @(posedge clk); #1; v8 = 1'b0;
    check("w8_clo_count", c8, 8);
    check("w8_clo_all", all8, 1);

    // 64-bit, 4 stages: appears after three further edges
    v64 = 1'b1; d64 = 64'h0; m64 = 2'b00; t64 = 5'd19;
    @(posedge clk); #1; v64 = 1'b0;
    tr = 0;
    while (!ov64 && tr < 10) begin
      @(posedge clk); #1;
      tr++;
    end
    check("w64_latency", tr, 3);
    check("w64_count", c64, 64);
    check("w64_all", all64, 1);
    check("w64_tag", ot64, 19);

    // Directed values, with latency check on the first
    send(32'h0001_0000, 2'b00, 5'd7, tr);
    check("lat_early", out_valid, 0);
    idle(1);
    check("lat_valid", out_valid, 1);
    idle(2);
    send(32'h0, 2'b00, 5'd1, tr);          idle(3);
    send(32'hFFFF_FFF0, 2'b01, 5'd2, tr);  idle(3);
    send(32'h8000_0000, 2'b10, 5'd3, tr);  idle(3);
    send(32'h0000_0007, 2'b11, 5'd4, tr);  idle(3);
    send(32'h0, 2'b10, 5'd5, tr);          idle(3);
    send(32'h8000_0000, 2'b00, 5'd6, tr);  idle(3);

    // Back-to-back stream: one accept per cycle and eight results on consecutive cycles
    p0 = pops;
    for (int i = 0; i < 8; i++) begin
      send($urandom, 2'($urandom_range(0, 3)), TW'(i), tr);
      check("b2b_accept", tr, 1);
      in_valid = 1'b1;
    end
    in_valid = 1'b0;
    idle(2);
    check("stream_count", pops - p0, 8);
    idle(2);

    // Backpressure: stall with pipe occupied, then release
    out_ready = 1'b0;
    p0 = pops;
    send(32'h0000_0100, 2'b00, 5'd10, tr);
    send(32'hF000_0000, 2'b01, 5'd11, tr);
    in_valid = 1'b1; in_data = 32'h0000_0030; in_mode = 2'b10; in_tag = 5'd12;
    for (int i = 0; i < 5; i++) begin
      check("full_in_ready", in_ready, 0);
      cyc(a);
    end
    out_ready = 1'b1;
    send(32'h0000_0030, 2'b10, 5'd12, tr);
    idle(4);
    check("stall_delivered", pops - p0, 3);
    check("stall_q_empty", q.size(), 0);

    // Flush with ops in flight plus one presented
    send(32'h0000_1000, 2'b00, 5'd13, tr);
    send(32'h0000_2000, 2'b00, 5'd14, tr);
    in_valid = 1'b1; in_data = 32'h1; in_mode = 2'b00; in_tag = 5'd15;
    flush = 1'b1;
    cyc(a);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_in_ready", a, 1);
    check("flush_valid0", out_valid, 0);
    p0 = pops;
    idle(3);
    check("flush_valid1", out_valid, 0);
    check("flush_no_pops", pops - p0, 0);
    send(32'h0000_0F00, 2'b11, 5'd16, tr);
    idle(3);
    check("post_flush_pop", pops - p0, 1);

    // Asynchronous reset with the pipe loaded
    out_ready = 1'b0;
    send(32'h1234_5678, 2'b00, 5'd20, tr);
    send(32'h0000_00FF, 2'b11, 5'd21, tr);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_count", out_count, 0);
    check("arst_tag", out_tag, 0);
    q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Random streaming with random backpressure
    for (int i = 0; i < 400; i++) begin
      d = $urandom;
      case ($urandom_range(0, 3))
        1: d = d >> $urandom_range(0, 31);
        2: d = d << $urandom_range(0, 31);
        3: d = ($urandom_range(0, 1) == 1) ? '0 : '1;
        default: ;
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = d;
      in_mode   = 2'($urandom_range(0, 3));
      in_tag    = TW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc(a);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tr = 0;
    while (q.size() > 0 && tr < 50) begin
      cyc(a);
      tr++;
    end
    check("drain_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
